// File: rtl/deco_sched.sv
// Two-port round-robin front end that feeds one Deco turbo-decoder: one frame in flight, result returned tagged with requester id.
// Optional WAIT-state abort: define DECO_SCHED_TIMEOUT_EN to enable the TIMEOUT watchdog (rsp_err_o tied 0 otherwise).
module deco_sched #(
   parameter int BEATS   = 4,
   parameter int BEAT_W  = 21,
   parameter int OUT_W   = 5,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16
) (
   input  logic                    clk_p_i,
   input  logic                    reset_p_i,
   input  logic                    req0_valid_i,
   input  logic [BEATS*BEAT_W-1:0] req0_frame_i,
   output logic                    req0_ready_o,
   input  logic                    req1_valid_i,
   input  logic [BEATS*BEAT_W-1:0] req1_frame_i,
   output logic                    req1_ready_o,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [OUT_W-1:0]        rsp_data_o,
   output logic                    rsp_id_o,
   output logic                    rsp_err_o,
   output logic                    deco_start_o,
   output logic [BEAT_W-1:0]       deco_data_o,
   input  logic [OUT_W-1:0]        deco_data_i,
   input  logic                    deco_done_i,
   output logic                    busy_o,
   output logic [CNT_W-1:0]        frame_cnt_o
);

   localparam int FRAME_W = BEATS * BEAT_W;
   localparam int IDX_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("deco_sched: TIMEOUT must be at least 1");
   end

   typedef enum logic [2:0] {IDLE, LOAD, HOLD, WAIT, RESP} state_t;

   state_t             state;
   logic               ptr;
   logic               id_q;
   logic [FRAME_W-1:0] frame_q;
   logic [IDX_W-1:0]   beat_cnt;
   logic [IDX_W-1:0]   beat_nxt;

   logic               fav_vld;
   logic               oth_vld;
   logic               grant_vld;
   logic               grant_id;
   logic [FRAME_W-1:0] grant_frame;

   function automatic logic [BEAT_W-1:0] beat_of(input logic [FRAME_W-1:0] f,
                                                 input logic [IDX_W-1:0]   k);
      return f[int'(k) * BEAT_W +: BEAT_W];
   endfunction

   // Favoured port is ptr; the other port only wins when ptr's port is idle.
   always_comb begin
      fav_vld     = ptr ? req1_valid_i : req0_valid_i;
      oth_vld     = ptr ? req0_valid_i : req1_valid_i;
      grant_vld   = fav_vld | oth_vld;
      grant_id    = fav_vld ? ptr : ~ptr;
      grant_frame = grant_id ? req1_frame_i : req0_frame_i;
      beat_nxt    = beat_cnt + IDX_W'(1);
   end

   assign req0_ready_o = (state == IDLE) && grant_vld && !grant_id;
   assign req1_ready_o = (state == IDLE) && grant_vld &&  grant_id;
   assign busy_o       = (state != IDLE);

`ifdef DECO_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] wait_cnt;
`else
   assign rsp_err_o = 1'b0;
`endif

   always_ff @(posedge clk_p_i) begin
      if (reset_p_i) begin
         state        <= IDLE;
         ptr          <= 1'b0;
         id_q         <= 1'b0;
         frame_q      <= '0;
         beat_cnt     <= '0;
         deco_start_o <= 1'b0;
         deco_data_o  <= '0;
         rsp_valid_o  <= 1'b0;
         rsp_data_o   <= '0;
         rsp_id_o     <= 1'b0;
         frame_cnt_o  <= '0;
`ifdef DECO_SCHED_TIMEOUT_EN
         rsp_err_o    <= 1'b0;
         wait_cnt     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  frame_q      <= grant_frame;
                  id_q         <= grant_id;
                  ptr          <= ~grant_id;
                  beat_cnt     <= '0;
                  deco_start_o <= 1'b1;
                  deco_data_o  <= grant_frame[BEAT_W-1:0];
                  state        <= LOAD;
               end
            end
            LOAD: begin
               if (beat_cnt == LAST_BEAT) begin
                  deco_data_o <= '0;
                  state       <= HOLD;
               end else begin
                  beat_cnt    <= beat_nxt;
                  deco_data_o <= beat_of(frame_q, beat_nxt);
               end
            end
            HOLD: begin
               deco_start_o <= 1'b0;
               state        <= WAIT;
`ifdef DECO_SCHED_TIMEOUT_EN
               wait_cnt     <= '0;
`endif
            end
            WAIT: begin
               // A done landing on the expiry cycle still delivers a normal result.
               if (deco_done_i) begin
                  rsp_data_o  <= deco_data_i;
                  rsp_id_o    <= id_q;
                  rsp_valid_o <= 1'b1;
`ifdef DECO_SCHED_TIMEOUT_EN
                  rsp_err_o   <= 1'b0;
`endif
                  state       <= RESP;
               end
`ifdef DECO_SCHED_TIMEOUT_EN
               else if (wait_cnt == TO_W'(TIMEOUT)) begin
                  rsp_data_o  <= '0;
                  rsp_id_o    <= id_q;
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= 1'b1;
                  state       <= RESP;
               end else begin
                  wait_cnt    <= wait_cnt + TO_W'(1);
               end
`endif
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  frame_cnt_o <= frame_cnt_o + CNT_W'(1);
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_deco_sched.sv
// Directed bench for deco_sched; timeout cases compile in only with DECO_SCHED_TIMEOUT_EN.
module tb_deco_sched;

   logic        clk_p_i = 1'b0;
   logic        reset_p_i;
   logic        req0_valid_i, req1_valid_i;
   logic [83:0] req0_frame_i, req1_frame_i;
   logic        req0_ready_o, req1_ready_o;
   logic        rsp_valid_o, rsp_ready_i;
   logic [4:0]  rsp_data_o;
   logic        rsp_id_o, rsp_err_o;
   logic        deco_start_o;
   logic [20:0] deco_data_o;
   logic [4:0]  deco_data_i;
   logic        deco_done_i;
   logic        busy_o;
   logic [15:0] frame_cnt_o;

   int n_chk = 0;
   int n_bad = 0;

   deco_sched #(.TIMEOUT(8)) dut (
      .clk_p_i(clk_p_i), .reset_p_i(reset_p_i),
      .req0_valid_i(req0_valid_i), .req0_frame_i(req0_frame_i), .req0_ready_o(req0_ready_o),
      .req1_valid_i(req1_valid_i), .req1_frame_i(req1_frame_i), .req1_ready_o(req1_ready_o),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
      .rsp_id_o(rsp_id_o), .rsp_err_o(rsp_err_o),
      .deco_start_o(deco_start_o), .deco_data_o(deco_data_o),
      .deco_data_i(deco_data_i), .deco_done_i(deco_done_i),
      .busy_o(busy_o), .frame_cnt_o(frame_cnt_o)
   );

   always #5 clk_p_i = ~clk_p_i;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   // Frames: beat k sits in bits [(k+1)*21-1 -: 21], so B0 is the low beat.
   localparam logic [83:0] FA = {21'h1FFFFF, 21'h0F0F0, 21'h12345, 21'h0000A5};
   localparam logic [83:0] FB = {21'h0AAAAA, 21'h155555, 21'h000001, 21'h100000};
   localparam logic [83:0] FC = {21'h000C0D, 21'h1E0E0E, 21'h07F07F, 21'h0ABCDE};
`ifdef DECO_SCHED_TIMEOUT_EN
   localparam int LAT1 = 8;
`else
   localparam int LAT1 = 14;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_p_i);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_start"}, 32'(deco_start_o), 0);
      chk({tag, "_ddata"}, 32'(deco_data_o), 0);
      chk({tag, "_rvld"},  32'(rsp_valid_o), 0);
      chk({tag, "_rdata"}, 32'(rsp_data_o), 0);
      chk({tag, "_rid"},   32'(rsp_id_o), 0);
      chk({tag, "_rerr"},  32'(rsp_err_o), 0);
      chk({tag, "_busy"},  32'(busy_o), 0);
      chk({tag, "_cnt"},   32'(frame_cnt_o), 0);
   endtask

   // Called in an IDLE cycle with the valids already set; runs one frame end to end.
   task automatic serve(input logic id, input logic [83:0] f, input logic [4:0] res,
                        input int lat, input int bp, input bit drop, input bit stray);
      #1;
      chk("rdy_win",  32'(id ? req1_ready_o : req0_ready_o), 1);
      chk("rdy_lose", 32'(id ? req0_ready_o : req1_ready_o), 0);
      cyc();
      if (drop) begin
         req0_valid_i = 1'b0;
         req1_valid_i = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
         chk("load_start", 32'(deco_start_o), 1);
         chk("load_beat",  32'(deco_data_o), 32'(f[k*21 +: 21]));
         chk("load_rdy",   32'({req0_ready_o, req1_ready_o}), 0);
         if (stray && k == 1) begin
            deco_done_i = 1'b1;
            deco_data_i = ~res;
         end
         cyc();
         deco_done_i = 1'b0;
         deco_data_i = '0;
      end
      chk("hold_start", 32'(deco_start_o), 1);
      chk("hold_data",  32'(deco_data_o), 0);
      cyc();
      chk("wait_start", 32'(deco_start_o), 0);
      chk("wait_rvld",  32'(rsp_valid_o), 0);
      repeat (lat) cyc();
      deco_done_i = 1'b1;
      deco_data_i = res;
      cyc();
      deco_done_i = 1'b0;
      deco_data_i = '0;
      chk("rsp_vld",  32'(rsp_valid_o), 1);
      chk("rsp_data", 32'(rsp_data_o), 32'(res));
      chk("rsp_id",   32'(rsp_id_o), 32'(id));
      chk("rsp_err",  32'(rsp_err_o), 0);
      for (int c = 0; c < bp; c++) begin
         cyc();
         chk("bp_vld",  32'(rsp_valid_o), 1);
         chk("bp_data", 32'(rsp_data_o), 32'(res));
         chk("bp_id",   32'(rsp_id_o), 32'(id));
         chk("bp_rdy",  32'({req0_ready_o, req1_ready_o}), 0);
      end
      rsp_ready_i = 1'b1;
      cyc();
      rsp_ready_i = 1'b0;
      chk("post_vld",  32'(rsp_valid_o), 0);
      chk("post_busy", 32'(busy_o), 0);
   endtask

   initial begin
      int n;
      reset_p_i    = 1'b1;
      req0_valid_i = 1'b0;  req1_valid_i = 1'b0;
      req0_frame_i = FA;    req1_frame_i = FB;
      rsp_ready_i  = 1'b0;
      deco_done_i  = 1'b0;  deco_data_i  = '0;
      cyc();
      cyc();
      chk_zero("rst");
      chk("rst_rdy", 32'({req0_ready_o, req1_ready_o}), 0);
      reset_p_i = 1'b0;

      // Single frame on port 0, done 20 cycles after accept when untimed.
      req0_valid_i = 1'b1;
      serve(1'b0, FA, 5'b10110, LAT1, 0, 1'b1, 1'b0);
      chk("single_cnt", 32'(frame_cnt_o), 1);

      // Reset while beat 2 is on the bus; ptr is 1 here.
      req1_valid_i = 1'b1;
      #1;
      chk("mid_rdy1", 32'(req1_ready_o), 1);
      cyc();
      req1_valid_i = 1'b0;
      cyc();
      cyc();
      chk("mid_beat2", 32'(deco_data_o), 32'(FB[62:42]));
      reset_p_i = 1'b1;
      cyc();
      reset_p_i = 1'b0;
      chk_zero("mid");
      req1_valid_i = 1'b1;
      serve(1'b1, FB, 5'b01101, 3, 0, 1'b1, 1'b0);
      chk("fresh_cnt", 32'(frame_cnt_o), 1);

      // Sustained contention alternates starting from port 0.
      req0_frame_i = FC;
      req0_valid_i = 1'b1;
      req1_valid_i = 1'b1;
      serve(1'b0, FC, 5'b00011, 2, 0, 1'b0, 1'b0);
      serve(1'b1, FB, 5'b11100, 0, 0, 1'b0, 1'b0);
      serve(1'b0, FC, 5'b10001, 5, 0, 1'b0, 1'b0);
      serve(1'b1, FB, 5'b01110, 1, 0, 1'b1, 1'b0);
      chk("cont_cnt", 32'(frame_cnt_o), 5);

      // Backpressure; ptr back at 0 so port 0 must win, then port 1 right after the handshake.
      req0_frame_i = FA;
      req0_valid_i = 1'b1;
      req1_valid_i = 1'b1;
      serve(1'b0, FA, 5'b11111, 4, 10, 1'b0, 1'b0);
      serve(1'b1, FB, 5'b00000, 2, 0, 1'b1, 1'b0);
      chk("bp_cnt", 32'(frame_cnt_o), 7);

      // Stray done during LOAD must not be captured.
      req0_valid_i = 1'b1;
      serve(1'b0, FA, 5'b01010, 3, 0, 1'b1, 1'b1);
      chk("stray_cnt", 32'(frame_cnt_o), 8);

`ifdef DECO_SCHED_TIMEOUT_EN
      // No done at all: abort 9 cycles after WAIT entry.
      req1_valid_i = 1'b1;
      #1;
      chk("to_rdy1", 32'(req1_ready_o), 1);
      cyc();
      req1_valid_i = 1'b0;
      repeat (5) cyc();
      chk("to_wait_start", 32'(deco_start_o), 0);
      n = 0;
      while (!rsp_valid_o && n < 50) begin
         cyc();
         n++;
      end
      chk("to_lat",  32'(n), 9);
      chk("to_err",  32'(rsp_err_o), 1);
      chk("to_data", 32'(rsp_data_o), 0);
      chk("to_id",   32'(rsp_id_o), 1);
      rsp_ready_i = 1'b1;
      cyc();
      rsp_ready_i = 1'b0;
      // Done on the expiry cycle wins.
      req0_valid_i = 1'b1;
      serve(1'b0, FA, 5'b10011, 8, 0, 1'b1, 1'b0);
      chk("to_cnt", 32'(frame_cnt_o), 10);
`else
      n = 0;
      chk("untimed_err", 32'(rsp_err_o), 32'(n));
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
